// File: rtl/hdmi_pkg.sv
// Shared constants for the HDMI receive phase tuner: TMDS control tokens and FSM states.
package hdmi_pkg;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_NEXT    = 3'd3,
        ST_APPLY   = 3'd4,
        ST_TRACK   = 3'd5,
        ST_FAIL    = 3'd6
    } hdmi_state_e;

    function automatic logic is_ctrl_token(input logic [9:0] word);
        return (word == CTRL_00) || (word == CTRL_01) ||
               (word == CTRL_10) || (word == CTRL_11);
    endfunction

endpackage

// File: rtl/tmds_phase_scorer.sv
// Counts clean TMDS control tokens on channel 0 over a 2^WINDOW_LOG2 cycle window.
module tmds_phase_scorer
    import hdmi_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   hdmi_valid,
    input  logic                   hdmi_locked,
    input  logic [9:0]             d0,
    output logic                   done,
    output logic [WINDOW_LOG2:0]   score,
    output logic                   disq
);

    logic                   active_q, active_d;
    logic [WINDOW_LOG2-1:0] win_q, win_d;
    logic [WINDOW_LOG2:0]   score_q, score_d;
    logic                   disq_q, disq_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            win_q    <= '0;
            score_q  <= '0;
            disq_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            win_q    <= win_d;
            score_q  <= score_d;
            disq_q   <= disq_d;
        end
    end

    always_comb begin
        active_d = active_q;
        win_d    = win_q;
        score_d  = score_q;
        disq_d   = disq_q;
        if (clear) begin
            active_d = 1'b0;
            win_d    = '0;
            score_d  = '0;
            disq_d   = 1'b0;
        end else if (start) begin
            active_d = 1'b1;
            win_d    = '0;
            score_d  = '0;
            disq_d   = 1'b0;
        end else if (active_q) begin
            win_d = win_q + 1'b1;
            if (hdmi_valid && is_ctrl_token(d0))
                score_d = score_q + 1'b1;
            if (!hdmi_valid || !hdmi_locked)
                disq_d = 1'b1;
            if (win_q == '1)
                active_d = 1'b0;
        end
    end

    assign done  = active_q && (win_q == '1);
    assign score = score_q;
    assign disq  = disq_q;

endmodule

// File: rtl/hdmi_phase_tuner.sv
// Sweeps the 4-bit PLL delay, scores each setting on channel 0, applies the best and tracks lock.
module hdmi_phase_tuner
    import hdmi_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned WINDOW_LOG2   = 16,
    parameter int unsigned MIN_SCORE     = 64,
    parameter int unsigned LOSS_LIMIT    = 4096,
    parameter int unsigned RETRY_CYCLES  = 65536
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hdmi_locked,
    input  logic                 hdmi_valid,
    input  logic [9:0]           d0,
    input  logic                 rescan,
    output logic [3:0]           pll_delay,
    output logic                 aligned,
    output logic                 scanning,
    output logic [WINDOW_LOG2:0] best_score,
    output logic [2:0]           state
);

    localparam int unsigned SCORE_W  = WINDOW_LOG2 + 1;
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned LOSS_W   = $clog2(LOSS_LIMIT + 1);
    localparam int unsigned RETRY_W  = $clog2(RETRY_CYCLES + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_LIMIT - 1);
    localparam logic [RETRY_W-1:0]  RETRY_LAST  = RETRY_W'(RETRY_CYCLES - 1);
    localparam logic [SCORE_W-1:0]  MIN_SCORE_V = SCORE_W'(MIN_SCORE);

    hdmi_state_e          state_q, state_d;
    logic [3:0]           pll_delay_q, pll_delay_d;
    logic [3:0]           best_delay_q, best_delay_d;
    logic [SCORE_W-1:0]   best_q, best_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [LOSS_W-1:0]    loss_q, loss_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 aligned_q, aligned_d;
    logic                 scanning_q, scanning_d;

    logic                 sc_start, sc_clear, sc_done, sc_disq;
    logic [SCORE_W-1:0]   sc_score;

    tmds_phase_scorer #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_scorer (
        .clk         (clk),
        .reset       (reset),
        .start       (sc_start),
        .clear       (sc_clear),
        .hdmi_valid  (hdmi_valid),
        .hdmi_locked (hdmi_locked),
        .d0          (d0),
        .done        (sc_done),
        .score       (sc_score),
        .disq        (sc_disq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pll_delay_q  <= '0;
            best_delay_q <= '0;
            best_q       <= '0;
            best_score_q <= '0;
            settle_q     <= '0;
            loss_q       <= '0;
            retry_q      <= '0;
            aligned_q    <= 1'b0;
            scanning_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pll_delay_q  <= pll_delay_d;
            best_delay_q <= best_delay_d;
            best_q       <= best_d;
            best_score_q <= best_score_d;
            settle_q     <= settle_d;
            loss_q       <= loss_d;
            retry_q      <= retry_d;
            aligned_q    <= aligned_d;
            scanning_q   <= scanning_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pll_delay_d  = pll_delay_q;
        best_delay_d = best_delay_q;
        best_d       = best_q;
        best_score_d = best_score_q;
        settle_d     = '0;
        loss_d       = '0;
        retry_d      = '0;
        sc_start     = 1'b0;
        sc_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hdmi_locked) begin
                    pll_delay_d  = '0;
                    best_d       = '0;
                    best_delay_d = '0;
                    sc_clear     = 1'b1;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Lock glitches after a delay change restart the settle count rather than abort.
                if (!hdmi_locked) begin
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    sc_start = 1'b1;
                    state_d  = ST_MEASURE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (sc_done)
                    state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (!sc_disq && (sc_score > best_q)) begin
                    best_d       = sc_score;
                    best_delay_d = pll_delay_q;
                end
                sc_clear = 1'b1;
                if (pll_delay_q == 4'd15) begin
                    state_d = ST_APPLY;
                end else begin
                    pll_delay_d = pll_delay_q + 4'd1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_APPLY: begin
                if (best_q >= MIN_SCORE_V) begin
                    pll_delay_d  = best_delay_q;
                    best_score_d = best_q;
                    state_d      = ST_TRACK;
                end else begin
                    pll_delay_d  = '0;
                    best_score_d = '0;
                    state_d      = ST_FAIL;
                end
            end
            ST_TRACK: begin
                if (!hdmi_locked) begin
                    state_d = ST_IDLE;
                end else if (!hdmi_valid) begin
                    if (loss_q == LOSS_LAST)
                        state_d = ST_IDLE;
                    else
                        loss_d = loss_q + 1'b1;
                end
            end
            ST_FAIL: begin
                if (!hdmi_locked || (retry_q == RETRY_LAST))
                    state_d = ST_IDLE;
                else
                    retry_d = retry_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // rescan overrides every register update computed above for this cycle.
        if (rescan && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            pll_delay_d  = pll_delay_q;
            best_delay_d = best_delay_q;
            best_d       = best_q;
            best_score_d = best_score_q;
            settle_d     = '0;
            loss_d       = '0;
            retry_d      = '0;
            sc_start     = 1'b0;
            sc_clear     = 1'b1;
        end

        aligned_d  = (state_q == ST_TRACK);
        scanning_d = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) ||
                     (state_q == ST_NEXT);
    end

    assign pll_delay  = pll_delay_q;
    assign aligned    = aligned_q;
    assign scanning   = scanning_q;
    assign best_score = best_score_q;
    assign state      = state_q;

endmodule
